// File: rtl/move_scheduler_if.sv
// Step handshake and key/position signals between the keyboard-side scheduler and game logic.
interface move_scheduler_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
);
  logic [3:0]     dir_held;
  logic           clear;
  logic           step_ready;
  logic           step_valid;
  logic [1:0]     step_dir;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           bump;

  modport master (
    input  dir_held, clear, step_ready,
    output step_valid, step_dir, pos_x, pos_y, bump
  );

  modport slave (
    output dir_held, clear, step_ready,
    input  step_valid, step_dir, pos_x, pos_y, bump
  );
endinterface

// File: rtl/move_scheduler.sv
// Held-key vector -> rate-limited typematic steps with a clamped grid position.
// Key rise to step_valid is two cycles; an offered step holds until accepted, timers freeze meanwhile.
module move_scheduler #(
  parameter int DELAY_CYC  = 25_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int X_MAX      = 15,
  parameter int Y_MAX      = 11,
  parameter int X_INIT     = 0,
  parameter int Y_INIT     = 0,
  parameter int CNT_W      = 25
) (
  input logic              clk,
  input logic              rst,
  move_scheduler_if.master bus
);
  localparam int X_W = $clog2(X_MAX + 1);
  localparam int Y_W = $clog2(Y_MAX + 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [X_W-1:0]   X_TOP  = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_TOP  = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]   X_RST  = X_W'(X_INIT);
  localparam logic [Y_W-1:0]   Y_RST  = Y_W'(Y_INIT);

  typedef enum logic [2:0] {IDLE, FIRST, WAIT_D, RPT, WAIT_R} state_t;

  state_t         state, state_nxt;
  logic [3:0]     dir_q;
  logic           own_vld, own_vld_nxt;
  logic [1:0]     own_dir, own_dir_nxt;
  logic           own_chg, owner_held;
  logic           restart;
  logic [CNT_W-1:0] timer;
  logic [1:0]     step_dir_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           bump_q;
  logic           step_vld, accept;
  logic           load_dir, enter_first, timer_clr;
  logic [3:0]     rise;

  // {found, dir}: UP > DOWN > LEFT > RIGHT, dir code d lives at key bit 3-d
  function automatic logic [2:0] pick(input logic [3:0] keys);
    logic [2:0] r;
    r = 3'b000;
    if (keys[3])      r = 3'b100;
    else if (keys[2]) r = 3'b101;
    else if (keys[1]) r = 3'b110;
    else if (keys[0]) r = 3'b111;
    return r;
  endfunction

  assign rise       = bus.dir_held & ~dir_q;
  assign owner_held = own_vld & bus.dir_held[~own_dir];
  assign step_vld   = (state == FIRST) || (state == RPT);
  assign accept     = step_vld & bus.step_ready;

  always_comb begin
    {own_vld_nxt, own_dir_nxt} = {own_vld, own_dir};
    if (|rise)            {own_vld_nxt, own_dir_nxt} = pick(rise);
    else if (!owner_held) {own_vld_nxt, own_dir_nxt} = pick(bus.dir_held);
  end

  assign own_chg = own_vld_nxt && (!own_vld || (own_dir_nxt != own_dir));

  always_comb begin
    state_nxt   = state;
    load_dir    = 1'b0;
    enter_first = 1'b0;
    timer_clr   = 1'b0;
    case (state)
      IDLE: if (own_vld) begin
        state_nxt   = FIRST;
        load_dir    = 1'b1;
        enter_first = 1'b1;
      end
      FIRST, RPT: if (accept) begin
        if (!own_vld) state_nxt = IDLE;
        else if (restart) begin
          state_nxt   = FIRST;
          load_dir    = 1'b1;
          enter_first = 1'b1;
        end else begin
          state_nxt = (state == FIRST) ? WAIT_D : WAIT_R;
          timer_clr = 1'b1;
        end
      end
      WAIT_D, WAIT_R: begin
        if (!own_vld) state_nxt = IDLE;
        else if (restart) begin
          state_nxt   = FIRST;
          load_dir    = 1'b1;
          enter_first = 1'b1;
        end else if (timer == ((state == WAIT_D) ? D_LAST : R_LAST)) begin
          state_nxt = RPT;
          load_dir  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 4'b0000;
    else     dir_q <= bus.dir_held;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      own_vld    <= 1'b0;
      own_dir    <= 2'd0;
      restart    <= 1'b0;
      timer      <= '0;
      step_dir_q <= 2'd0;
    end else if (bus.clear) begin
      state      <= IDLE;
      own_vld    <= 1'b0;
      own_dir    <= 2'd0;
      restart    <= 1'b0;
      timer      <= '0;
      step_dir_q <= 2'd0;
    end else begin
      state   <= state_nxt;
      own_vld <= own_vld_nxt;
      own_dir <= own_dir_nxt;
      // a change seen while a step is pending is remembered until FIRST is re-entered
      if (own_chg)          restart <= 1'b1;
      else if (enter_first) restart <= 1'b0;
      // timer holds cycles elapsed since the accept, so the next offer lands exactly LAST+1 later
      if (timer_clr) timer <= CNT_W'(1);
      else if ((state == WAIT_D) || (state == WAIT_R)) timer <= timer + 1'b1;
      if (load_dir) step_dir_q <= own_dir;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= X_RST;
      y_q    <= Y_RST;
      bump_q <= 1'b0;
    end else if (bus.clear) begin
      x_q    <= X_RST;
      y_q    <= Y_RST;
      bump_q <= 1'b0;
    end else begin
      bump_q <= 1'b0;
      if (accept) begin
        case (step_dir_q)
          2'd0:    if (y_q == '0)   bump_q <= 1'b1; else y_q <= y_q - 1'b1;
          2'd1:    if (y_q == Y_TOP) bump_q <= 1'b1; else y_q <= y_q + 1'b1;
          2'd2:    if (x_q == '0)   bump_q <= 1'b1; else x_q <= x_q - 1'b1;
          default: if (x_q == X_TOP) bump_q <= 1'b1; else x_q <= x_q + 1'b1;
        endcase
      end
    end
  end

  assign bus.step_valid = step_vld;
  assign bus.step_dir   = step_dir_q;
  assign bus.pos_x      = x_q;
  assign bus.pos_y      = y_q;
  assign bus.bump       = bump_q;
endmodule
